sequence_check: RTL and testbench

//  Player-input checker for the memory/sequence game. After the display stage signals

---
 rtl/sequence_check.sv | 120 ++++++++++++
 tb/tb_sequence_check.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_check.sv
// Player-input checker for the memory/sequence game: after display_done, compares each
// button press against the next digit of S_in and flags correct/incorrect.
module sequence_check #(
  parameter int MAX_LVL = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             player_num,
  input  logic                   b_player,
  input  logic [4*MAX_LVL-1:0]   S_in,
  input  logic [2:0]             LVL,
  input  logic                   display_done,
  output logic [4:0]             RAM_addr,
  output logic                   RAM_r,
  output logic                   correct,
  output logic                   incorrect
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_PRESS,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           n_q, n_d;
  logic [4:0]           addr_q, addr_d;
  logic                 correct_q, correct_d;
  logic                 incorrect_q, incorrect_d;
  logic                 b_prev_q;

  logic                 press;
  logic [2:0]           lvl_clamped;
  logic [4*MAX_LVL-1:0] seq_shift;
  logic [3:0]           digit;

  always_comb begin
    lvl_clamped = LVL;
    if (LVL == 3'd0) begin
      lvl_clamped = 3'd1;
    end else if (LVL > 3'(MAX_LVL)) begin
      lvl_clamped = 3'(MAX_LVL);
    end
  end

  // Digit idx sits at the MSB end once the sequence is shifted left by idx nibbles.
  always_comb begin
    seq_shift = S_in << {idx_q, 2'b00};
    digit     = seq_shift[4*MAX_LVL-1 -: 4];
  end

  assign press = b_player & ~b_prev_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    addr_d      = addr_q;
    correct_d   = correct_q;
    incorrect_d = incorrect_q;

    if (display_done) begin
      state_d     = FETCH;
      idx_d       = '0;
      correct_d   = 1'b0;
      incorrect_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          n_d     = lvl_clamped;
          addr_d  = {2'b00, lvl_clamped};
          state_d = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press) begin
            if (player_num != digit) begin
              incorrect_d = 1'b1;
              state_d     = DONE;
            end else if (idx_q == n_q - 3'd1) begin
              correct_d = 1'b1;
              state_d   = DONE;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= 3'd1;
      addr_q      <= '0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      b_prev_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      b_prev_q    <= b_player;
    end
  end

  // The address is shown during FETCH itself and held afterwards.
  assign RAM_addr  = (state_q == FETCH) ? {2'b00, lvl_clamped} : addr_q;
  assign RAM_r     = (state_q == FETCH);
  assign correct   = correct_q;
  assign incorrect = incorrect_q;

endmodule

// File: tb/tb_sequence_check.sv
// Directed bench for sequence_check: a behavioural model checked every cycle plus
// hand-computed literal expectations at key points of each scenario.
module tb_sequence_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  player_num = 4'h0;
  logic        b_player = 1'b0;
  logic [19:0] S_in = '0;
  logic [2:0]  LVL = 3'd1;
  logic        display_done = 1'b0;
  logic [4:0]  RAM_addr;
  logic        RAM_r;
  logic        correct;
  logic        incorrect;

  int n_checks = 0;
  int n_err    = 0;

  // Model: a pending fetch cycle, then a run of expected positions into S_in.
  bit m_fetch, m_armed, m_correct, m_incorrect, m_prev_b;
  int m_addr, m_count, m_pos;

  sequence_check #(.MAX_LVL(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .player_num   (player_num),
    .b_player     (b_player),
    .S_in         (S_in),
    .LVL          (LVL),
    .display_done (display_done),
    .RAM_addr     (RAM_addr),
    .RAM_r        (RAM_r),
    .correct      (correct),
    .incorrect    (incorrect)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int l);
    if (l == 0) return 1;
    if (l > 5) return 5;
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 0; m_armed = 0; m_correct = 0; m_incorrect = 0;
    m_prev_b = 0; m_addr = 0; m_count = 0; m_pos = 0;
  endtask

  task automatic model_edge();
    bit pr;
    int want;
    if (!rst) begin
      model_reset();
    end else begin
      pr = b_player && !m_prev_b;
      m_prev_b = b_player;
      if (display_done) begin
        m_fetch = 1; m_armed = 0; m_correct = 0; m_incorrect = 0; m_pos = 0;
      end else if (m_fetch) begin
        m_fetch = 0; m_armed = 1; m_count = clamp(int'(LVL));
        m_addr = m_count; m_pos = 0;
      end else if (m_armed && pr) begin
        want = int'((S_in >> (4 * (4 - m_pos))) & 20'hF);
        if (int'(player_num) != want) begin
          m_incorrect = 1; m_armed = 0;
        end else begin
          m_pos++;
          if (m_pos == m_count) begin
            m_correct = 1; m_armed = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    int exp_addr;
    exp_addr = m_fetch ? clamp(int'(LVL)) : m_addr;
    chk("correct", 32'(correct), 32'(m_correct));
    chk("incorrect", 32'(incorrect), 32'(m_incorrect));
    chk("ram_r", 32'(RAM_r), 32'(m_fetch));
    chk("ram_addr", 32'(RAM_addr), 32'(exp_addr));
    chk("exclusive", 32'(correct & incorrect), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic press(input logic [3:0] d);
    player_num = d;
    b_player = 1'b1;
    tick();
    b_player = 1'b0;
    tick();
  endtask

  // Pulse display_done, then step through the fetch cycle into the press wait.
  task automatic restart(input logic [2:0] lvl, input logic [19:0] seq, input int exp_addr);
    LVL = lvl;
    S_in = seq;
    display_done = 1'b1;
    tick();
    display_done = 1'b0;
    chk("fetch_ram_r", 32'(RAM_r), 32'd1);
    chk("fetch_addr", 32'(RAM_addr), 32'(exp_addr));
    tick();
    chk("post_fetch_ram_r", 32'(RAM_r), 32'd0);
    chk("post_fetch_flags", {30'd0, correct, incorrect}, 32'd0);
  endtask

  initial begin
    model_reset();
    #1;
    compare();
    chk("rst_correct", 32'(correct), 32'd0);
    chk("rst_incorrect", 32'(incorrect), 32'd0);
    chk("rst_ram_r", 32'(RAM_r), 32'd0);
    chk("rst_addr", 32'(RAM_addr), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    press(4'h1);
    press(4'h2);
    chk("idle_flags", {30'd0, correct, incorrect}, 32'd0);

    // Full level-5 match.
    restart(3'd5, 20'h123AC, 5);
    chk("addr_held", 32'(RAM_addr), 32'd5);
    press(4'h1); press(4'h2); press(4'h3); press(4'hA);
    player_num = 4'hC;
    b_player = 1'b1;
    chk("before_last", 32'(correct), 32'd0);
    tick();
    b_player = 1'b0;
    chk("l5_correct", 32'(correct), 32'd1);
    chk("l5_incorrect", 32'(incorrect), 32'd0);
    tick();

    // Mismatch on the third digit.
    restart(3'd5, 20'h123AC, 5);
    press(4'h1); press(4'h2);
    player_num = 4'h4;
    b_player = 1'b1;
    tick();
    b_player = 1'b0;
    chk("mm_incorrect", 32'(incorrect), 32'd1);
    chk("mm_correct", 32'(correct), 32'd0);
    tick();
    press(4'h3); press(4'hA); press(4'hC);
    chk("done_hold", {30'd0, correct, incorrect}, 32'd1);

    // Short levels and LVL clamping.
    restart(3'd1, 20'hA0000, 1);
    press(4'hA);
    chk("l1_correct", 32'(correct), 32'd1);
    restart(3'd3, 20'h12300, 3);
    press(4'h1); press(4'h2);
    chk("l3_mid", 32'(correct), 32'd0);
    press(4'h3);
    chk("l3_correct", 32'(correct), 32'd1);
    restart(3'd0, 20'hB0000, 1);
    press(4'hB);
    chk("lvl0_correct", 32'(correct), 32'd1);
    restart(3'd7, 20'h11111, 5);

    // S_in is read live at each press.
    restart(3'd2, 20'h12000, 2);
    press(4'h1);
    S_in = 20'h15000;
    press(4'h5);
    chk("live_sin", 32'(correct), 32'd1);

    // Held button counts once.
    restart(3'd5, 20'h11111, 5);
    player_num = 4'h1;
    b_player = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    b_player = 1'b0;
    tick();
    chk("held_no_correct", {30'd0, correct, incorrect}, 32'd0);
    press(4'h1); press(4'h1); press(4'h1);
    chk("held_still_waiting", 32'(correct), 32'd0);
    press(4'h1);
    chk("held_correct", 32'(correct), 32'd1);
    display_done = 1'b1;
    tick();
    display_done = 1'b0;
    chk("restart_clears", 32'(correct), 32'd0);
    tick();

    // display_done wins over a simultaneous wrong press.
    player_num = 4'h9;
    b_player = 1'b1;
    display_done = 1'b1;
    tick();
    display_done = 1'b0;
    b_player = 1'b0;
    tick();
    chk("priority_flags", {30'd0, correct, incorrect}, 32'd0);

    // Reset in the middle of a level.
    restart(3'd5, 20'h123AC, 5);
    press(4'h1); press(4'h2);
    rst = 1'b0;
    model_reset();
    #1;
    compare();
    chk("midrst_outputs", {25'd0, RAM_addr, RAM_r, correct, incorrect}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    press(4'h3); press(4'hA); press(4'hC);
    chk("postrst_idle", {30'd0, correct, incorrect}, 32'd0);
    chk("postrst_addr", 32'(RAM_addr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
